// File: rtl/bmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// bmem_arbiter_if
// Bundles the cache-side dfp handshake of all requesters and the shared 64-bit
// burst memory (bmem) port into one interface.
//   slave  : arbiter view (consumes requests and bmem returns, drives commands)
//   master : environment view (requesters plus memory model)
// Signals:
//   req_addr   [NUM_REQ*32]   line address per requester, slice r = [32r+:32]
//   req_read   [NUM_REQ]      read request, held until resp
//   req_write  [NUM_REQ]      write request, held until resp
//   req_wdata  [NUM_REQ*256]  write line per requester
//   req_rdata  [NUM_REQ*256]  assembled read line, valid while resp[r] is high
//   req_resp   [NUM_REQ]      one-cycle completion pulse
//   bmem_addr/read/write/wdata  command / write-beat channel to memory
//   bmem_ready                  memory accepts the command or beat this cycle
//   bmem_raddr/rdata/rvalid     tagged read-return channel from memory
// -----------------------------------------------------------------------------
interface bmem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ*32-1:0]  req_addr;
  logic [NUM_REQ-1:0]     req_read;
  logic [NUM_REQ-1:0]     req_write;
  logic [NUM_REQ*256-1:0] req_wdata;
  logic [NUM_REQ*256-1:0] req_rdata;
  logic [NUM_REQ-1:0]     req_resp;

  logic [31:0]            bmem_addr;
  logic                   bmem_read;
  logic                   bmem_write;
  logic [63:0]            bmem_wdata;
  logic                   bmem_ready;
  logic [31:0]            bmem_raddr;
  logic [63:0]            bmem_rdata;
  logic                   bmem_rvalid;

  modport slave (
    input  req_addr, req_read, req_write, req_wdata,
    output req_rdata, req_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output req_addr, req_read, req_write, req_wdata,
    input  req_rdata, req_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_arbiter.sv
// -----------------------------------------------------------------------------
// bmem_arbiter
// Round-robin sharing of the single 64-bit burst memory port among NUM_REQ
// cacheline requesters (0 = icache, 1 = dcache, 2+ = others). Reads are issued
// as single-cycle commands with one outstanding read per requester; returned
// beats are matched by bmem_raddr and reassembled into a 256-bit line. Writes
// are serialized as 4-beat bursts.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        bmem_arbiter_if.slave (requester handshake + bmem port)
// Optional (macro BMEM_ARB_PERF_EN):
//   perf_rd_issue [NUM_REQ*32]  read commands accepted per requester
//   perf_wr_issue [NUM_REQ*32]  write bursts completed per requester
//   perf_stall    [32]          cycles with an eligible but unserved requester
//   All counters saturate and clear on rst.
// -----------------------------------------------------------------------------
module bmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int BEATS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef BMEM_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0] perf_rd_issue,
  output logic [NUM_REQ*32-1:0] perf_wr_issue,
  output logic [31:0]           perf_stall,
`endif
  bmem_arbiter_if.slave         bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {ST_FREE, ST_RD_WAIT, ST_DONE} req_st_e;
  typedef enum logic       {S_IDLE, S_WRITE}              fsm_e;

  // Per-requester read tracking
  req_st_e          r_status [NUM_REQ];
  logic [31:0]      r_addr   [NUM_REQ];
  logic [1:0]       r_cnt    [NUM_REQ];
  logic [255:0]     r_line   [NUM_REQ];

  // Arbitration / write burst state
  fsm_e             r_state, w_state_nx;
  logic [IDX_W-1:0] r_rr_ptr, r_hold_idx, r_wr_idx;
  logic             r_hold_vld;
  logic [1:0]       r_beat;
  logic [31:0]      r_waddr;
  logic [255:0]     r_wdata;

  logic [NUM_REQ-1:0] w_addr_busy, w_elig, w_match;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_vld, w_win_is_wr;
  logic               w_accept_rd, w_accept_wr, w_last_beat;

  // A read may not share its tag with any in-flight read, otherwise returning
  // beats could not be attributed to one entry.
  always_comb begin
    w_addr_busy = '0;
    w_elig      = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (r_status[k] == ST_RD_WAIT && r_addr[k] == bus.req_addr[32*r +: 32])
          w_addr_busy[r] = 1'b1;
      end
      if (!rst && r_status[r] == ST_FREE)
        w_elig[r] = bus.req_write[r] || (bus.req_read[r] && !w_addr_busy[r]);
    end
  end

  // Winner selection: a requester stalled by bmem_ready keeps the grant;
  // otherwise search round-robin starting after the last accepted winner.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    if (r_hold_vld && w_elig[r_hold_idx]) begin
      w_win_vld = 1'b1;
      w_win_idx = r_hold_idx;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        if (!w_win_vld && w_elig[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
          w_win_vld = 1'b1;
          w_win_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
        end
      end
    end
    w_win_is_wr = bus.req_write[w_win_idx];
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nx      = r_state;
    w_accept_rd     = 1'b0;
    w_accept_wr     = 1'b0;
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_addr   = r_waddr;
    bus.bmem_wdata  = r_wdata[64*r_beat +: 64];
    unique case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          bus.bmem_addr = bus.req_addr[32*w_win_idx +: 32];
          if (w_win_is_wr) begin
            bus.bmem_write = 1'b1;
            bus.bmem_wdata = bus.req_wdata[256*w_win_idx +: 64];
            if (bus.bmem_ready) begin
              w_accept_wr = 1'b1;
              w_state_nx  = S_WRITE;
            end
          end else begin
            bus.bmem_read = 1'b1;
            w_accept_rd   = bus.bmem_ready;
          end
        end
      end
      S_WRITE: begin
        bus.bmem_write = 1'b1;
        if (bus.bmem_ready && r_beat == LAST_BEAT)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_last_beat = (r_state == S_WRITE) && bus.bmem_ready && (r_beat == LAST_BEAT);

  // Beat capture runs regardless of FSM state, so returns overlap write bursts.
  always_comb begin
    w_match = '0;
    for (int r = 0; r < NUM_REQ; r++)
      w_match[r] = !rst && bus.bmem_rvalid && r_status[r] == ST_RD_WAIT &&
                   r_addr[r] == bus.bmem_raddr;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; later assignments to the same element in this block win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_hold_vld <= 1'b0;
      r_hold_idx <= '0;
      r_wr_idx   <= '0;
      r_beat     <= '0;
      for (int r = 0; r < NUM_REQ; r++) r_status[r] <= ST_FREE;
    end else begin
      r_state    <= w_state_nx;
      r_hold_vld <= (r_state == S_IDLE) && w_win_vld && !bus.bmem_ready;
      r_hold_idx <= w_win_idx;
      if (w_accept_rd || w_accept_wr) r_rr_ptr <= w_win_idx;

      if (w_accept_wr) begin
        r_wr_idx <= w_win_idx;
        r_beat   <= 2'd1;
      end else if (r_state == S_WRITE && bus.bmem_ready) begin
        r_beat   <= r_beat + 2'd1;
      end

      for (int r = 0; r < NUM_REQ; r++) begin
        case (r_status[r])
          ST_DONE:    r_status[r] <= ST_FREE;
          ST_RD_WAIT: if (w_match[r] && r_cnt[r] == LAST_BEAT) r_status[r] <= ST_DONE;
          default:    ;
        endcase
      end
      if (w_accept_rd) r_status[w_win_idx] <= ST_RD_WAIT;
      // A finished writer reuses DONE for its resp pulse; this also keeps it
      // ineligible while its request is still high during that cycle.
      if (w_last_beat) r_status[r_wr_idx] <= ST_DONE;
    end
  end

  // NOTE: line buffers, tags and write data carry no reset; r_status gates
  // every use of them, and the line is cleared when its read is issued.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_match[r]) begin
        r_line[r][64*r_cnt[r] +: 64] <= r_line[r][64*r_cnt[r] +: 64] | bus.bmem_rdata;
        r_cnt[r]                     <= r_cnt[r] + 2'd1;
      end
    end
    if (w_accept_rd) begin
      r_addr[w_win_idx] <= bus.req_addr[32*w_win_idx +: 32];
      r_cnt[w_win_idx]  <= '0;
      r_line[w_win_idx] <= '0;
    end
    if (w_accept_wr) begin
      r_waddr <= bus.req_addr[32*w_win_idx +: 32];
      r_wdata <= bus.req_wdata[256*w_win_idx +: 256];
    end
  end

  always_comb begin
    bus.req_resp  = '0;
    bus.req_rdata = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_resp[r]              = (r_status[r] == ST_DONE);
      bus.req_rdata[256*r +: 256]  = r_line[r];
    end
  end

  // Protocol checks
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REQ; r++)
        assert (!(bus.req_read[r] && bus.req_write[r]));
      if (bus.bmem_rvalid)
        assert (|w_match);
    end
  end

`ifdef BMEM_ARB_PERF_EN
  logic [31:0] r_perf_rd [NUM_REQ];
  logic [31:0] r_perf_wr [NUM_REQ];
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        r_perf_rd[r] <= '0;
        r_perf_wr[r] <= '0;
      end
    end else begin
      if (w_accept_rd && r_perf_rd[w_win_idx] != '1)
        r_perf_rd[w_win_idx] <= r_perf_rd[w_win_idx] + 32'd1;
      if (w_last_beat && r_perf_wr[r_wr_idx] != '1)
        r_perf_wr[r_wr_idx] <= r_perf_wr[r_wr_idx] + 32'd1;
      if (|w_elig && !(w_accept_rd || w_accept_wr) && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  always_comb begin
    perf_rd_issue = '0;
    perf_wr_issue = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      perf_rd_issue[32*r +: 32] = r_perf_rd[r];
      perf_wr_issue[32*r +: 32] = r_perf_wr[r];
    end
  end
  assign perf_stall = r_perf_stall;
`endif

endmodule
